// File: rtl/sm3_msg_byte_pckr.sv
`default_nettype none
// ============================================================================
//  Module   : sm3_msg_byte_pckr
//  Purpose  : Transmit side of the SM3 message-input interface. Packs a
//             valid/ready byte stream MSB-first into INPT_DW-wide words for
//             sm3_pad_core. A byte flagged last always closes the current
//             word, so one output word never holds bytes of two messages.
//  Ports    : clk, rst_n            clock / async active-low reset
//             byte_d/vld/lst/rdy    byte-side handshake
//             msg_inpt_d            packed word, first byte in the top 8 bits
//             msg_inpt_vld_byte     MSB-aligned valid-byte mask
//             msg_inpt_vld/lst/rdy  word-side handshake
//             msg_byte_cnt          bytes accepted in current/last message
//  Revision : 1.0  initial release
// ============================================================================
module sm3_msg_byte_pckr #(
  parameter int INPT_DW = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             byte_d,
  input  logic                   byte_vld,
  input  logic                   byte_lst,
  output logic                   byte_rdy,
  output logic [INPT_DW-1:0]     msg_inpt_d,
  output logic [INPT_DW/8-1:0]   msg_inpt_vld_byte,
  output logic                   msg_inpt_vld,
  output logic                   msg_inpt_lst,
  input  logic                   msg_inpt_rdy,
  output logic [60:0]            msg_byte_cnt
);

  localparam int BYTE_NUM = INPT_DW / 8;
  localparam int KW       = (BYTE_NUM > 1) ? $clog2(BYTE_NUM) : 1;

  localparam logic [KW-1:0]       c_K_LAST  = KW'(BYTE_NUM - 1);
  localparam logic [BYTE_NUM-1:0] c_ONES    = {BYTE_NUM{1'b1}};
  localparam logic [60:0]         c_CNT_MAX = {61{1'b1}};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACTV = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [INPT_DW-1:0]    r_acc;
  logic [KW-1:0]         r_k;
  logic [INPT_DW-1:0]    r_d;
  logic [BYTE_NUM-1:0]   r_vb;
  logic                  r_vld;
  logic                  r_lst;
  logic [60:0]           r_cnt;

  logic                  w_byte_acc;
  logic                  w_complete;
  logic [INPT_DW-1:0]    w_byte_pos;
  logic [INPT_DW-1:0]    w_acc_new;
  logic [KW:0]           w_nbytes;
  logic [BYTE_NUM-1:0]   w_mask;

  // A new byte can only enter when the output register is free or is being
  // drained this very cycle, so a completing byte never overwrites a word.
  assign byte_rdy   = ~r_vld | msg_inpt_rdy;
  assign w_byte_acc = byte_vld & byte_rdy;
  assign w_complete = w_byte_acc & (byte_lst | (r_k == c_K_LAST));

  // Place the incoming byte at slot k counting from the MSB end.
  assign w_byte_pos = {byte_d, {(INPT_DW-8){1'b0}}} >> {r_k, 3'b000};
  assign w_acc_new  = r_acc | w_byte_pos;

  // k+1 ones from the MSB: clear the low (BYTE_NUM-k-1) bits of an all-ones mask.
  assign w_nbytes   = {1'b0, r_k} + (KW+1)'(1);
  assign w_mask     = ~(c_ONES >> w_nbytes);

  // Message-open state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_byte_acc && !byte_lst) w_state_nxt = ACTV;
      ACTV:    if (w_byte_acc &&  byte_lst) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Accumulator and byte index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_k   <= '0;
    end else if (w_byte_acc) begin
      if (w_complete) begin
        r_acc <= '0;
        r_k   <= '0;
      end else begin
        r_acc <= w_acc_new;
        r_k   <= r_k + KW'(1);
      end
    end
  end

  // Output word register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d   <= '0;
      r_vb  <= '0;
      r_vld <= 1'b0;
      r_lst <= 1'b0;
    end else if (w_complete) begin
      r_d   <= w_acc_new;
      r_vb  <= w_mask;
      r_vld <= 1'b1;
      r_lst <= byte_lst;
    end else if (r_vld && msg_inpt_rdy) begin
      r_vld <= 1'b0;
      r_lst <= 1'b0;
    end
  end

  // Message length; holds after the last byte until the next message opens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_byte_acc) begin
      if (r_state == IDLE) begin
        r_cnt <= 61'd1;
      end else if (r_cnt != c_CNT_MAX) begin
        r_cnt <= r_cnt + 61'd1;
      end
    end
  end

  assign msg_inpt_d        = r_d;
  assign msg_inpt_vld_byte = r_vb;
  assign msg_inpt_vld      = r_vld;
  assign msg_inpt_lst      = r_lst;
  assign msg_byte_cnt      = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sm3_msg_byte_pckr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sm3_msg_byte_pckr
//  Purpose  : Self-checking bench for sm3_msg_byte_pckr. A 32-bit instance
//             sees random backpressure; a 64-bit instance receives exactly
//             the same accepted bytes with its downstream always ready.
//             Expected words come from a byte-list reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sm3_msg_byte_pckr;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  m;
    logic        l;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  byte_d = 8'h00;
  logic        byte_vld = 1'b0;
  logic        byte_lst = 1'b0;
  logic        rdy32 = 1'b1;
  int          rdy_mode = 0;

  logic        byte_rdy32, byte_rdy64;
  logic [31:0] d32;
  logic [63:0] d64;
  logic [3:0]  vb32;
  logic [7:0]  vb64;
  logic        vld32, vld64, lst32, lst64;
  logic [60:0] cnt32, cnt64;
  logic        w_vld64;

  // 64-bit copy only sees bytes the 32-bit instance actually takes.
  assign w_vld64 = byte_vld & byte_rdy32;

  sm3_msg_byte_pckr #(.INPT_DW(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .byte_d(byte_d), .byte_vld(byte_vld),
    .byte_lst(byte_lst), .byte_rdy(byte_rdy32), .msg_inpt_d(d32),
    .msg_inpt_vld_byte(vb32), .msg_inpt_vld(vld32), .msg_inpt_lst(lst32),
    .msg_inpt_rdy(rdy32), .msg_byte_cnt(cnt32)
  );

  sm3_msg_byte_pckr #(.INPT_DW(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .byte_d(byte_d), .byte_vld(w_vld64),
    .byte_lst(byte_lst), .byte_rdy(byte_rdy64), .msg_inpt_d(d64),
    .msg_inpt_vld_byte(vb64), .msg_inpt_vld(vld64), .msg_inpt_lst(lst64),
    .msg_inpt_rdy(1'b1), .msg_byte_cnt(cnt64)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Reference model state
  logic [7:0] p32[$];
  logic [7:0] p64[$];
  exp_t       q32[$];
  exp_t       q64[$];
  logic [60:0] m_cnt = '0;
  bit          m_open = 1'b0;
  exp_t        last32, last64;
  int          nw32 = 0;
  bit          mon_en = 1'b0;

  function automatic exp_t mk(input logic [7:0] p[$], input int bn, input logic l);
    exp_t e;
    int   n;
    n   = p.size();
    e.d = '0;
    foreach (p[i]) e.d = (e.d << 8) | 64'(p[i]);
    e.d = e.d << (8 * (bn - n));
    e.m = 8'(((1 << n) - 1) << (bn - n));
    e.l = l;
    return e;
  endfunction

  function automatic void model_accept(input logic [7:0] b, input logic l);
    m_cnt  = m_open ? m_cnt + 61'd1 : 61'd1;
    m_open = !l;
    p32.push_back(b);
    p64.push_back(b);
    if (p32.size() == 4 || l) begin q32.push_back(mk(p32, 4, l)); p32.delete(); end
    if (p64.size() == 8 || l) begin q64.push_back(mk(p64, 8, l)); p64.delete(); end
  endfunction

  function automatic void model_reset();
    p32.delete(); p64.delete(); q32.delete(); q64.delete();
    m_cnt = '0; m_open = 1'b0;
  endfunction

  // Monitor: compare outputs, retire accepted words, then record the byte
  // that the coming rising edge will take.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("vld32", 64'(vld32), 64'(q32.size() != 0));
      if (vld32 && q32.size() != 0) begin
        chk("d32",  64'(d32),  q32[0].d);
        chk("vb32", 64'(vb32), 64'(q32[0].m));
        chk("lst32", 64'(lst32), 64'(q32[0].l));
        if (rdy32) begin last32 = q32.pop_front(); nw32++; end
      end
      chk("vld64", 64'(vld64), 64'(q64.size() != 0));
      if (vld64 && q64.size() != 0) begin
        chk("d64",  d64, q64[0].d);
        chk("vb64", 64'(vb64), 64'(q64[0].m));
        chk("lst64", 64'(lst64), 64'(q64[0].l));
        last64 = q64.pop_front();
      end
      chk("brdy32", 64'(byte_rdy32), 64'(!vld32 || rdy32));
      chk("brdy64", 64'(byte_rdy64), 64'd1);
      chk("cnt32", 64'(cnt32), 64'(m_cnt));
      chk("cnt64", 64'(cnt64), 64'(m_cnt));
      if (byte_vld && byte_rdy32) model_accept(byte_d, byte_lst);
    end
  end

  // Downstream ready for the 32-bit instance
  always @(posedge clk) begin
    #1;
    rdy32 = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
  end

  task automatic send_byte(input logic [7:0] b, input logic l);
    bit acc;
    int guard;
    byte_vld = 1'b1; byte_d = b; byte_lst = l;
    guard = 0;
    do begin
      @(negedge clk);
      acc = byte_rdy32;
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 1000);
    if (!acc) chk("byte_timeout", 64'd1, 64'd0);
    byte_vld = 1'b0; byte_lst = 1'b0;
  endtask

  task automatic send_msg(input logic [7:0] m[$], input int max_gap);
    foreach (m[i]) begin
      send_byte(m[i], i == m.size() - 1);
      repeat ($urandom_range(0, max_gap)) @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((q32.size() != 0 || q64.size() != 0) && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    if (guard >= 200) chk("drain_timeout", 64'd1, 64'd0);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_vld32", 64'(vld32), 64'd0);
    chk("rst_vld64", 64'(vld64), 64'd0);
    chk("rst_cnt32", 64'(cnt32), 64'd0);
    chk("rst_d32",   64'(d32),   64'd0);
    chk("rst_vb64",  64'(vb64),  64'd0);
    chk("rst_brdy",  64'(byte_rdy32), 64'd1);
    byte_vld = 1'b0; byte_lst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  logic [7:0] msg[$];
  int         w0;

  initial begin
    @(posedge clk); #1;
    do_reset();

    // 'abc'
    msg = '{8'h61, 8'h62, 8'h63};
    send_msg(msg, 0); drain();
    chk("abc_cnt", 64'(cnt32), 64'd3);
    chk("abc_d32", last32.d, 64'h6162_6300);
    chk("abc_vb32", 64'(last32.m), 64'h0e);
    chk("abc_d64", last64.d, 64'h6162_6300_0000_0000);
    chk("abc_vb64", 64'(last64.m), 64'he0);

    // 64 bytes 'abcd', full rate then with backpressure
    for (int pass = 0; pass < 2; pass++) begin
      rdy_mode = pass;
      msg.delete();
      for (int i = 0; i < 64; i++) msg.push_back(8'h61 + 8'(i % 4));
      w0 = nw32;
      send_msg(msg, 0); drain();
      chk("abcd_words", 64'(nw32 - w0), 64'd16);
      chk("abcd_cnt", 64'(cnt64), 64'd64);
      chk("abcd_last", last32.d, 64'h6162_6364);
    end
    rdy_mode = 0;

    // Reset after 6 bytes of an open message, then 'abc'
    msg = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    foreach (msg[i]) send_byte(msg[i], 1'b0);
    do_reset();
    msg = '{8'h61, 8'h62, 8'h63};
    w0 = nw32;
    send_msg(msg, 0); drain();
    chk("rst_abc_words", 64'(nw32 - w0), 64'd1);
    chk("rst_abc_d32", last32.d, 64'h6162_6300);

    // Back-to-back messages
    msg = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_msg(msg, 0);
    @(negedge clk);
    chk("b2b_cnt5", 64'(cnt32), 64'd5);
    @(posedge clk); #1;
    msg = '{8'h61, 8'h62, 8'h63};
    send_msg(msg, 0); drain();
    chk("b2b_cnt3", 64'(cnt32), 64'd3);

    // Random messages, gaps and backpressure
    rdy_mode = 1;
    for (int n = 0; n < 40; n++) begin
      msg.delete();
      for (int i = 0; i < $urandom_range(1, 40); i++) msg.push_back(8'($urandom));
      send_msg(msg, $urandom_range(0, 2));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
